// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and the default inter-byte gap.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT0,
    ST_WAIT,
    ST_GAP
  } arb_state_t;

  localparam int DEFAULT_CHAR_GAP = 8500;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_tx-side signals of the arbiter; slave is the arbiter, master is everything around it.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   last;
  logic [8*N_REQ-1:0] data;
  logic [N_REQ-1:0]   ack;
  logic [N_REQ-1:0]   grant;
  logic               busy;
  logic               uart_transmit;
  logic [7:0]         uart_tx_byte;
  logic               uart_is_transmitting;

  modport master (
    output req, last, data, uart_is_transmitting,
    input  ack, grant, busy, uart_transmit, uart_tx_byte
  );

  modport slave (
    input  req, last, data, uart_is_transmitting,
    output ack, grant, busy, uart_transmit, uart_tx_byte
  );
endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: lowest requesting index at or above ptr, wrapping to index 0.
module uart_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic             any
);
  logic [N_REQ-1:0] hi_mask;
  logic [N_REQ-1:0] hi_req;
  logic [N_REQ-1:0] cand;

  // Requests at or above ptr win; otherwise fall back to the full vector (the wrap).
  assign hi_mask = ~((N_REQ'(1) << ptr) - N_REQ'(1));
  assign hi_req  = req & hi_mask;
  assign cand    = (|hi_req) ? hi_req : req;
  assign pick    = cand & (~cand + N_REQ'(1));
  assign any     = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of a single uart_tx for whole messages. Build macro UART_ARB_CHAR_GAP_EN
// enables the CHAR_GAP idle counter after each byte; without it GAP is a single cycle.
//
// state | meaning
// IDLE  | no owner; pick one round-robin from ptr when any req is high
// LOAD  | take the owner's byte (ack) or drop ownership if its req fell
// SEND  | one-cycle uart_transmit pulse
// WAIT0 | absorb the uart_tx busy-flag latency
// WAIT  | hold until uart_is_transmitting falls
// GAP   | inter-byte idle; then next byte, or release after the last one
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int CHAR_GAP = DEFAULT_CHAR_GAP,
  parameter int GAP_W    = $clog2(CHAR_GAP + 1)
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(N_REQ);

  arb_state_t       state, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] pick;
  logic             any;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner, after_owner;
  logic             last_q, last_d;
  logic [7:0]       byte_q, byte_d;
  logic             own_req, own_last;
  logic [7:0]       own_data;
  logic             gap_done;

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req  (bus.req),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any)
  );

  always_comb begin
    owner    = '0;
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        owner    = PTR_W'(i);
        own_req  = bus.req[i];
        own_last = bus.last[i];
        own_data = bus.data[8*i +: 8];
      end
    end
    after_owner = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
  end

`ifdef UART_ARB_CHAR_GAP_EN
  localparam int CNT_W    = (GAP_W > 0) ? GAP_W : 1;
  localparam int GAP_LAST = (CHAR_GAP > 0) ? CHAR_GAP - 1 : 0;

  logic [CNT_W-1:0] gap_cnt;

  // Held at zero outside GAP, so every GAP visit starts counting from 0.
  always_ff @(posedge clk) begin
    if (rst || state != ST_GAP) gap_cnt <= '0;
    else                        gap_cnt <= gap_cnt + 1'b1;
  end

  assign gap_done = (gap_cnt == CNT_W'(GAP_LAST));
`else
  // Without the counter the gap parameters are inert; any legal values give a one-cycle GAP.
  assign gap_done = (CHAR_GAP >= 0) || (GAP_W >= 0);
`endif

  always_comb begin
    state_d = state;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    byte_d  = byte_q;
    unique case (state)
      ST_IDLE: begin
        if (any) begin
          grant_d = pick;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (own_req) begin
          byte_d  = own_data;
          last_d  = own_last;
          state_d = ST_SEND;
        end else begin
          grant_d = '0;
          ptr_d   = after_owner;
          state_d = ST_IDLE;
        end
      end
      ST_SEND:  state_d = ST_WAIT0;
      ST_WAIT0: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!bus.uart_is_transmitting) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_done) begin
          if (last_q) begin
            grant_d = '0;
            ptr_d   = after_owner;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      last_q  <= 1'b0;
      byte_q  <= '0;
    end else begin
      state   <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      byte_q  <= byte_d;
    end
  end

  // Pulses are gated by rst so they drop in the very cycle reset is asserted.
  assign bus.ack           = (state == ST_LOAD && !rst) ? (grant_q & bus.req) : '0;
  assign bus.uart_transmit = (state == ST_SEND) && !rst;
  assign bus.grant         = grant_q;
  assign bus.busy          = (state != ST_IDLE);
  assign bus.uart_tx_byte  = byte_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random message mixes
// checked against a message-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int CG = 4;
`ifdef UART_ARB_CHAR_GAP_EN
  localparam int GAP_LEN = (CG > 0) ? CG : 1;
`else
  localparam int GAP_LEN = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(NR)) bus ();

  uart_tx_arbiter #(
    .N_REQ    (NR),
    .CHAR_GAP (CG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t_tx = 10;
  int busy_cnt = 0;
  bit pend = 0;
  int model_ptr = 0;
  int ack_first = -1;

  logic [8:0] rq [NR][$];
  int         log_cyc[$];
  int         log_own[$];
  logic [7:0] log_byte[$];
  int         exp_own[$];
  logic [7:0] exp_byte[$];
  logic [NR-1:0] ghist [int];

  logic [NR-1:0] s_ack, s_grant;
  logic          s_tx, s_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int oh_idx(input logic [NR-1:0] g);
    for (int i = 0; i < NR; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic drive();
    logic [8:0] e;
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() > 0) begin
        e = rq[i][0];
        bus.req[i]         = 1'b1;
        bus.last[i]        = e[8];
        bus.data[8*i +: 8] = e[7:0];
      end else begin
        bus.req[i]         = 1'b0;
        bus.last[i]        = 1'b0;
        bus.data[8*i +: 8] = 8'h00;
      end
    end
    bus.uart_is_transmitting = (busy_cnt != 0);
  endtask

  // One clock: sample at negedge, then update requesters and the uart_tx model after the edge.
  task automatic tick();
    @(negedge clk);
    s_ack   = bus.ack;
    s_grant = bus.grant;
    s_tx    = bus.uart_transmit;
    s_busy  = bus.busy;
    ghist[cyc] = s_grant;
    if (!rst) chk("grant_onehot0", 32'($onehot0(s_grant)), 32'd1);
    if (s_ack != '0 && ack_first < 0) ack_first = cyc;
    if (s_tx) begin
      log_cyc.push_back(cyc);
      log_own.push_back(oh_idx(s_grant));
      log_byte.push_back(bus.uart_tx_byte);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++)
      if (s_ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    if (busy_cnt > 0) busy_cnt--;
    if (pend) begin
      busy_cnt = t_tx;
      pend = 0;
    end
    if (s_tx) pend = 1;
    drive();
  endtask

  // Message-level model: whole messages leave in round-robin order starting at ptr;
  // a queue that runs dry before a last-flagged byte ends the message as an abort.
  function automatic void build_expect();
    logic [8:0] cp [NR][$];
    logic [8:0] e;
    int p, j;
    bit found;
    for (int i = 0; i < NR; i++) cp[i] = rq[i];
    exp_own.delete();
    exp_byte.delete();
    p = model_ptr;
    forever begin
      found = 0;
      j = 0;
      for (int k = 0; k < NR; k++) begin
        if (!found && cp[(p + k) % NR].size() > 0) begin
          found = 1;
          j = (p + k) % NR;
        end
      end
      if (!found) break;
      while (cp[j].size() > 0) begin
        e = cp[j].pop_front();
        exp_own.push_back(j);
        exp_byte.push_back(e[7:0]);
        if (e[8]) break;
      end
      p = (j + 1) % NR;
    end
    model_ptr = p;
  endfunction

  task automatic run_phase(input string tag);
    bit done;
    int n;
    build_expect();
    log_cyc.delete();
    log_own.delete();
    log_byte.delete();
    ack_first = -1;
    done = 0;
    drive();
    for (int k = 0; k < 4000; k++) begin
      tick();
      if (rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 && rq[3].size() == 0 && !s_busy) begin
        done = 1;
        break;
      end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_nbytes"}, 32'(log_byte.size()), 32'(exp_byte.size()));
    n = (log_byte.size() < exp_byte.size()) ? log_byte.size() : exp_byte.size();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_byte%0d", tag, k), 32'(log_byte[k]), 32'(exp_byte[k]));
      chk($sformatf("%s_owner%0d", tag, k), 32'(log_own[k]), 32'(exp_own[k]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive();
    tick();
    tick();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_transmit", 32'(bus.uart_transmit), 32'd0);
    chk("rst_tx_byte", 32'(bus.uart_tx_byte), 32'd0);
    rst = 1'b0;
    model_ptr = 0;
    drive();
  endtask

  initial begin
    int c0, s, nmsg, len;
    bit seen;
    logic [8:0] e;

    bus.req = '0;
    bus.last = '0;
    bus.data = '0;
    bus.uart_is_transmitting = 1'b0;
    do_reset();

    // Single message "AB" from requester 0
    t_tx = 10;
    rq[0].push_back(9'h041);
    rq[0].push_back(9'h142);
    c0 = cyc;
    run_phase("single");
    chk("single_idle_c0", 32'(ghist[c0]), 32'd0);
    chk("single_grant_c1", 32'(ghist[c0 + 1]), 32'b0001);
    chk("single_ack_c1", 32'(ack_first), 32'(c0 + 1));
    chk("single_tx_c2", 32'(log_cyc[0]), 32'(c0 + 2));
    chk("single_b0", 32'(log_byte[0]), 32'h41);
    chk("single_b1", 32'(log_byte[1]), 32'h42);
    chk("single_period", 32'(log_cyc[1] - log_cyc[0]), 32'(4 + t_tx + GAP_LEN));
    chk("single_grant_in_gap", 32'(ghist[log_cyc[1] + t_tx + 2 + GAP_LEN]), 32'b0001);
    chk("single_grant_drop", 32'(ghist[log_cyc[1] + t_tx + 3 + GAP_LEN]), 32'd0);

    // Contention between requesters 1 and 2
    rq[1].push_back(9'h011);
    rq[1].push_back(9'h112);
    rq[2].push_back(9'h021);
    rq[2].push_back(9'h122);
    run_phase("contend");
    chk("contend_order", {log_own[0][7:0], log_own[1][7:0], log_own[2][7:0], log_own[3][7:0]},
        32'h01010202);

    // Fairness: 0 and 3 keep re-requesting one-byte messages
    do_reset();
    t_tx = 3;
    for (int k = 0; k < 4; k++) begin
      rq[0].push_back(9'h100 | 9'(k));
      rq[3].push_back(9'h130 | 9'(k));
    end
    run_phase("fair");
    for (int k = 0; k < 8; k++)
      chk($sformatf("fair_alt%0d", k), 32'(log_own[k]), (k % 2 == 0) ? 32'd0 : 32'd3);

    // Abort: requester 2 offers one non-last byte then drops req
    rq[2].push_back(9'h0A5);
    run_phase("abort");
    chk("abort_idle", 32'(s_grant), 32'd0);
    rq[0].push_back(9'h1C0);
    rq[3].push_back(9'h1C3);
    run_phase("abort_ptr");
    chk("abort_ptr3_first", 32'(log_own[0]), 32'd3);

    // Reset while the owner is in WAIT
    t_tx = 10;
    rq[0].push_back(9'h061);
    rq[0].push_back(9'h162);
    drive();
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick();
      seen = s_tx;
    end
    chk("rstwait_tx_seen", 32'(seen), 32'd1);
    tick();
    s = cyc;
    rq[0].delete();
    rq[1].push_back(9'h15A);
    rst = 1'b1;
    drive();
    tick();
    rst = 1'b0;
    drive();
    chk("rstwait_cycle", 32'(cyc), 32'(s + 1));
    chk("rstwait_grant0", 32'(bus.grant), 32'd0);
    chk("rstwait_ack0", 32'(bus.ack), 32'd0);
    chk("rstwait_busy0", 32'(bus.busy), 32'd0);
    chk("rstwait_tx0", 32'(bus.uart_transmit), 32'd0);
    chk("rstwait_byte0", 32'(bus.uart_tx_byte), 32'd0);
    tick();
    chk("rstwait_regrant", 32'(bus.grant), 32'b0010);
    model_ptr = 0;
    run_phase("post_rst");

    // Random message mixes
    for (int r = 0; r < 6; r++) begin
      t_tx = $urandom_range(1, 12);
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          nmsg = $urandom_range(1, 2);
          for (int m = 0; m < nmsg; m++) begin
            len = $urandom_range(1, 3);
            for (int b = 0; b < len; b++) begin
              e = {(b == len - 1), 8'($urandom)};
              rq[i].push_back(e);
            end
          end
          if ($urandom_range(0, 5) == 0) begin
            e = rq[i][rq[i].size() - 1];
            e[8] = 1'b0;
            rq[i][rq[i].size() - 1] = e;
          end
        end
      end
      if (rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size() == 0)
        rq[$urandom_range(0, NR - 1)].push_back({1'b1, 8'($urandom)});
      run_phase($sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed cycle %0d required completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
